// File: rtl/mi_uart_pkg.sv
// Shared constants and state encoding for the mi_io_uart IO-bus UART.
package mi_uart_pkg;

  localparam logic [1:0] RegData  = 2'd0;
  localparam logic [1:0] RegStat  = 2'd1;
  localparam logic [1:0] RegBaud  = 2'd2;
  localparam logic [1:0] RegIrqEn = 2'd3;

  localparam int unsigned StatTxFull     = 0;
  localparam int unsigned StatTxEmpty    = 1;
  localparam int unsigned StatRxEmpty    = 2;
  localparam int unsigned StatRxFull     = 3;
  localparam int unsigned StatRxOverrun  = 4;
  localparam int unsigned StatFrameErr   = 5;
  localparam int unsigned StatTxOverflow = 6;
  localparam int unsigned StatTxBusy     = 7;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uartState_t;

  // W1C helper: keep a sticky flag unless cleared, a new set event always wins.
  function automatic logic stickyNext(input logic cur, input logic setEv, input logic clrEv);
    return setEv | (cur & ~clrEv);
  endfunction

endpackage

// File: rtl/mi_fifo_sync.sv
// Synchronous FIFO with clock enable; dout shows the head entry combinationally.
module mi_fifo_sync #(
  parameter int unsigned CWidth = 8,
  parameter int unsigned CDepth = 8
) (
  input  logic              AClkH,
  input  logic              AResetH,
  input  logic              AClkHEn,
  input  logic              push,
  input  logic              pop,
  input  logic [CWidth-1:0] din,
  output logic [CWidth-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int unsigned CAw = $clog2(CDepth);

  logic [CWidth-1:0] mem [CDepth];
  logic [CAw:0]      wrPtr;
  logic [CAw:0]      rdPtr;
  logic              doPush;
  logic              doPop;

  // A pop frees the slot a simultaneous push into a full FIFO needs.
  always_comb begin
    doPop  = pop & ~empty;
    doPush = push & (~full | doPop);
  end

  assign full  = (wrPtr[CAw] != rdPtr[CAw]) && (wrPtr[CAw-1:0] == rdPtr[CAw-1:0]);
  assign empty = (wrPtr == rdPtr);
  assign dout  = mem[rdPtr[CAw-1:0]];

  // Storage and pointer update.
  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      wrPtr <= '0;
      rdPtr <= '0;
      for (int i = 0; i < int'(CDepth); i++) begin
        mem[i] <= '0;
      end
    end else if (AClkHEn) begin
      if (doPush) begin
        mem[wrPtr[CAw-1:0]] <= din;
        wrPtr <= wrPtr + (CAw+1)'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + (CAw+1)'(1);
      end
    end
  end

endmodule

// File: rtl/mi_io_uart.sv
// IO-bus UART: register window, TX/RX FIFOs, 8N1 serialiser and deserialiser.
// Optional interrupt output and IRQEN register built in when MI_UART_IRQ_EN is defined.
module mi_io_uart
  import mi_uart_pkg::*;
#(
  parameter logic [15:0] CBaseAddr    = 16'h0100,
  parameter int unsigned CFifoDepth   = 8,
  parameter logic [15:0] CBaudDefault = 16'd867
) (
  input  logic        AClkH,
  input  logic        AResetH,
  input  logic        AClkHEn,
  input  logic [15:0] AIoAddr,
  input  logic [31:0] AIoMosi,
  input  logic [2:0]  AIoWrSize,
  input  logic [2:0]  AIoRdSize,
  output logic [31:0] AIoMiso,
  input  logic        ADataI,
  output logic        ADataO
`ifdef MI_UART_IRQ_EN
  ,
  output logic        AIrq
`endif
);

  logic        sel;
  logic [1:0]  offset;
  logic        ioWr;
  logic        ioRd;
  logic [31:0] readData;
  logic [7:0]  stat;
  logic        unusedBits;

  logic [15:0] baud;
  logic        rxOverrun;
  logic        frameErr;
  logic        txOverflow;

  logic        txPush;
  logic        txPop;
  logic [7:0]  txHead;
  logic        txFull;
  logic        txEmpty;
  logic        txOverflowSet;

  logic        rxPush;
  logic        rxPop;
  logic [7:0]  rxHead;
  logic        rxFull;
  logic        rxEmpty;
  logic        rxOverrunSet;
  logic        frameErrSet;

  uartState_t  txState;
  logic [15:0] txCnt;
  logic [15:0] txBaud;
  logic [3:0]  txBitCnt;
  logic [7:0]  txShift;

  uartState_t  rxState;
  logic [15:0] rxCnt;
  logic [15:0] rxBaud;
  logic [3:0]  rxBitCnt;
  logic [7:0]  rxShift;
  logic        rxSync1;
  logic        rxSync2;
  logic        rxLast;

`ifdef MI_UART_IRQ_EN
  logic [2:0]  irqEn;
`endif

  assign unusedBits = ^{AIoMosi[31:16], AIoAddr[1:0]};

  // Bus decode and FIFO/flag event generation; a write suppresses a same-cycle read.
  always_comb begin
    sel           = (AIoAddr[15:4] == CBaseAddr[15:4]);
    offset        = AIoAddr[3:2];
    ioWr          = AClkHEn & sel & (AIoWrSize != 3'b000);
    ioRd          = AClkHEn & sel & (AIoRdSize != 3'b000) & (AIoWrSize == 3'b000);
    txPush        = ioWr & (offset == RegData);
    rxPop         = ioRd & (offset == RegData);
    txPop         = AClkHEn & ~txEmpty &
                    ((txState == StIdle) | ((txState == StStop) & (txCnt == 16'd0)));
    rxPush        = AClkHEn & (rxState == StStop) & (rxCnt == 16'd0) & rxSync2;
    frameErrSet   = AClkHEn & (rxState == StStop) & (rxCnt == 16'd0) & ~rxSync2;
    txOverflowSet = txPush & txFull & ~txPop;
    rxOverrunSet  = rxPush & rxFull & ~rxPop;
  end

  // Status word and read mux.
  always_comb begin
    stat                 = 8'h00;
    stat[StatTxFull]     = txFull;
    stat[StatTxEmpty]    = txEmpty;
    stat[StatRxEmpty]    = rxEmpty;
    stat[StatRxFull]     = rxFull;
    stat[StatRxOverrun]  = rxOverrun;
    stat[StatFrameErr]   = frameErr;
    stat[StatTxOverflow] = txOverflow;
    stat[StatTxBusy]     = (txState != StIdle);
    case (offset)
      RegData:  readData = rxEmpty ? 32'h0 : {24'h0, rxHead};
      RegStat:  readData = {24'h0, stat};
      RegBaud:  readData = {16'h0, baud};
`ifdef MI_UART_IRQ_EN
      RegIrqEn: readData = {29'h0, irqEn};
`else
      RegIrqEn: readData = 32'h0;
`endif
      default:  readData = 32'h0;
    endcase
  end

  mi_fifo_sync #(.CWidth(8), .CDepth(CFifoDepth)) uTxFifo (
    .AClkH   (AClkH),
    .AResetH (AResetH),
    .AClkHEn (AClkHEn),
    .push    (txPush),
    .pop     (txPop),
    .din     (AIoMosi[7:0]),
    .dout    (txHead),
    .full    (txFull),
    .empty   (txEmpty)
  );

  mi_fifo_sync #(.CWidth(8), .CDepth(CFifoDepth)) uRxFifo (
    .AClkH   (AClkH),
    .AResetH (AResetH),
    .AClkHEn (AClkHEn),
    .push    (rxPush),
    .pop     (rxPop),
    .din     (rxShift),
    .dout    (rxHead),
    .full    (rxFull),
    .empty   (rxEmpty)
  );

  // Configuration registers, sticky flags and registered read data.
  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      baud       <= CBaudDefault;
      rxOverrun  <= 1'b0;
      frameErr   <= 1'b0;
      txOverflow <= 1'b0;
      AIoMiso    <= 32'h0;
`ifdef MI_UART_IRQ_EN
      irqEn      <= 3'b000;
`endif
    end else if (AClkHEn) begin
      if (ioWr && (offset == RegBaud)) begin
        baud <= AIoMosi[15:0];
      end
`ifdef MI_UART_IRQ_EN
      if (ioWr && (offset == RegIrqEn)) begin
        irqEn <= AIoMosi[2:0];
      end
`endif
      rxOverrun  <= stickyNext(rxOverrun, rxOverrunSet,
                               ioWr & (offset == RegStat) & AIoMosi[StatRxOverrun]);
      frameErr   <= stickyNext(frameErr, frameErrSet,
                               ioWr & (offset == RegStat) & AIoMosi[StatFrameErr]);
      txOverflow <= stickyNext(txOverflow, txOverflowSet,
                               ioWr & (offset == RegStat) & AIoMosi[StatTxOverflow]);
      AIoMiso    <= ioRd ? readData : 32'h0;
    end
  end

  // TX serialiser; BAUD is latched per frame, STOP chains straight into the next START.
  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      txState  <= StIdle;
      txCnt    <= 16'd0;
      txBaud   <= CBaudDefault;
      txBitCnt <= 4'd0;
      txShift  <= 8'h00;
      ADataO   <= 1'b1;
    end else if (AClkHEn) begin
      case (txState)
        StIdle: begin
          if (!txEmpty) begin
            txShift  <= txHead;
            txBaud   <= baud;
            txCnt    <= baud;
            txBitCnt <= 4'd0;
            ADataO   <= 1'b0;
            txState  <= StStart;
          end else begin
            ADataO   <= 1'b1;
          end
        end
        StStart: begin
          if (txCnt == 16'd0) begin
            ADataO  <= txShift[0];
            txShift <= {1'b0, txShift[7:1]};
            txCnt   <= txBaud;
            txState <= StData;
          end else begin
            txCnt <= txCnt - 16'd1;
          end
        end
        StData: begin
          if (txCnt == 16'd0) begin
            txCnt <= txBaud;
            if (txBitCnt == 4'd7) begin
              ADataO  <= 1'b1;
              txState <= StStop;
            end else begin
              ADataO   <= txShift[0];
              txShift  <= {1'b0, txShift[7:1]};
              txBitCnt <= txBitCnt + 4'd1;
            end
          end else begin
            txCnt <= txCnt - 16'd1;
          end
        end
        StStop: begin
          if (txCnt == 16'd0) begin
            if (!txEmpty) begin
              txShift  <= txHead;
              txBaud   <= baud;
              txCnt    <= baud;
              txBitCnt <= 4'd0;
              ADataO   <= 1'b0;
              txState  <= StStart;
            end else begin
              ADataO  <= 1'b1;
              txState <= StIdle;
            end
          end else begin
            txCnt <= txCnt - 16'd1;
          end
        end
        default: begin
          ADataO  <= 1'b1;
          txState <= StIdle;
        end
      endcase
    end
  end

  // RX synchroniser and deserialiser; the start bit is re-checked at mid-bit to reject glitches.
  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      rxSync1  <= 1'b1;
      rxSync2  <= 1'b1;
      rxLast   <= 1'b1;
      rxState  <= StIdle;
      rxCnt    <= 16'd0;
      rxBaud   <= CBaudDefault;
      rxBitCnt <= 4'd0;
      rxShift  <= 8'h00;
    end else if (AClkHEn) begin
      rxSync1 <= ADataI;
      rxSync2 <= rxSync1;
      rxLast  <= rxSync2;
      case (rxState)
        StIdle: begin
          if (rxLast && !rxSync2) begin
            rxBaud   <= baud;
            rxCnt    <= baud >> 1;
            rxBitCnt <= 4'd0;
            rxState  <= StStart;
          end
        end
        StStart: begin
          if (rxCnt == 16'd0) begin
            rxCnt   <= rxBaud;
            rxState <= rxSync2 ? StIdle : StData;
          end else begin
            rxCnt <= rxCnt - 16'd1;
          end
        end
        StData: begin
          if (rxCnt == 16'd0) begin
            rxShift <= {rxSync2, rxShift[7:1]};
            rxCnt   <= rxBaud;
            if (rxBitCnt == 4'd7) begin
              rxState <= StStop;
            end else begin
              rxBitCnt <= rxBitCnt + 4'd1;
            end
          end else begin
            rxCnt <= rxCnt - 16'd1;
          end
        end
        StStop: begin
          if (rxCnt == 16'd0) begin
            rxState <= StIdle;
          end else begin
            rxCnt <= rxCnt - 16'd1;
          end
        end
        default: rxState <= StIdle;
      endcase
    end
  end

`ifdef MI_UART_IRQ_EN
  // Interrupt: OR of enabled conditions, one cycle behind the state it reflects.
  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      AIrq <= 1'b0;
    end else if (AClkHEn) begin
      AIrq <= |(irqEn & {rxOverrun | frameErr | txOverflow, txEmpty, ~rxEmpty});
    end
  end
`endif

endmodule

// File: tb/tb_mi_io_uart.sv
// Directed, table-driven bench for mi_io_uart (BAUD = 3 gives 4-cycle bits).
module tb_mi_io_uart;

  localparam logic [15:0] AData = 16'h0100;
  localparam logic [15:0] AStat = 16'h0104;
  localparam logic [15:0] ABaud = 16'h0108;
  localparam logic [15:0] ARsv  = 16'h010C;

  logic        AClkH = 1'b0;
  logic        AResetH;
  logic        AClkHEn;
  logic [15:0] AIoAddr;
  logic [31:0] AIoMosi;
  logic [2:0]  AIoWrSize;
  logic [2:0]  AIoRdSize;
  logic [31:0] AIoMiso;
  logic        ADataI;
  logic        ADataO;
`ifdef MI_UART_IRQ_EN
  logic        AIrq;
`endif

  int nChecks = 0;
  int nPass   = 0;

  typedef struct {
    bit          isWr;
    logic [15:0] addr;
    logic [31:0] data;
  } vec_t;

  vec_t vecs[14];

  mi_io_uart dut (
    .AClkH     (AClkH),
    .AResetH   (AResetH),
    .AClkHEn   (AClkHEn),
    .AIoAddr   (AIoAddr),
    .AIoMosi   (AIoMosi),
    .AIoWrSize (AIoWrSize),
    .AIoRdSize (AIoRdSize),
    .AIoMiso   (AIoMiso),
    .ADataI    (ADataI),
    .ADataO    (ADataO)
`ifdef MI_UART_IRQ_EN
    ,
    .AIrq      (AIrq)
`endif
  );

  always #5 AClkH = ~AClkH;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic busWrite(input logic [15:0] a, input logic [31:0] d);
    @(negedge AClkH);
    AIoAddr = a; AIoMosi = d; AIoWrSize = 3'b010;
    @(negedge AClkH);
    AIoWrSize = 3'b000; AIoMosi = 32'h0;
  endtask

  task automatic busRead(input logic [15:0] a, output logic [31:0] d);
    @(negedge AClkH);
    AIoAddr = a; AIoRdSize = 3'b010;
    @(negedge AClkH);
    AIoRdSize = 3'b000;
    d = AIoMiso;
  endtask

  task automatic readCheck(input string name, input logic [15:0] a, input logic [31:0] exp);
    logic [31:0] d;
    busRead(a, d);
    checkVal(name, d, exp);
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic stopBit);
    logic [9:0] f;
    f = {stopBit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge AClkH);
      ADataI = f[i];
      repeat (3) @(negedge AClkH);
    end
    @(negedge AClkH);
    ADataI = 1'b1;
    repeat (7) @(negedge AClkH);
  endtask

  initial begin
    logic [9:0]  txFrame;
    logic [31:0] d;
    bit          found;

    AResetH = 1'b1; AClkHEn = 1'b1; AIoAddr = 16'h0; AIoMosi = 32'h0;
    AIoWrSize = 3'b000; AIoRdSize = 3'b000; ADataI = 1'b1;
    repeat (3) @(negedge AClkH);
    checkVal("rstMiso", AIoMiso, 32'h0);
    checkVal("rstDataO", {31'h0, ADataO}, 32'h1);
    AResetH = 1'b0;

    vecs[0]  = '{1'b0, AStat, 32'h0000_0006};
    vecs[1]  = '{1'b0, ABaud, 32'd867};
    vecs[2]  = '{1'b0, ARsv, 32'h0};
    vecs[3]  = '{1'b0, 16'h0204, 32'h0};
    vecs[4]  = '{1'b1, ABaud, 32'hFFFF_1234};
    vecs[5]  = '{1'b0, ABaud, 32'h0000_1234};
    vecs[6]  = '{1'b1, ARsv, 32'hFFFF_FFFF};
`ifdef MI_UART_IRQ_EN
    vecs[7]  = '{1'b0, ARsv, 32'h7};
`else
    vecs[7]  = '{1'b0, ARsv, 32'h0};
`endif
    vecs[8]  = '{1'b1, ARsv, 32'h0};
    vecs[9]  = '{1'b1, AStat, 32'hFF};
    vecs[10] = '{1'b0, AStat, 32'h0000_0006};
    vecs[11] = '{1'b0, 16'h0109, 32'h0000_1234};
    vecs[12] = '{1'b1, ABaud, 32'h3};
    vecs[13] = '{1'b0, ABaud, 32'h3};
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].isWr) busWrite(vecs[i].addr, vecs[i].data);
      else readCheck($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data);
    end

    // TX frame for 8'hA5, each bit held 4 cycles.
    txFrame = {1'b1, 8'hA5, 1'b0};
    busWrite(AData, 32'hA5);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge AClkH);
      if (ADataO == 1'b0) found = 1'b1;
    end
    checkVal("txStartSeen", {31'h0, found}, 32'h1);
    for (int j = 0; j < 40; j++) begin
      if (j > 0) @(negedge AClkH);
      checkVal($sformatf("txBit%0d", j), {31'h0, ADataO}, {31'h0, txFrame[j/4]});
    end
    readCheck("txDoneStat", AStat, 32'h06);
    busWrite(AData, 32'hFF);
    repeat (2) @(negedge AClkH);
    readCheck("txBusyStat", AStat, 32'h86);
    repeat (50) @(negedge AClkH);
    readCheck("txIdleStat", AStat, 32'h06);

    // RX single frame, then empty read.
    sendFrame(8'h3C, 1'b1);
    readCheck("rxStat", AStat, 32'h02);
    readCheck("rxData", AData, 32'h3C);
    readCheck("rxEmptyRead", AData, 32'h0);
    readCheck("rxEmptyStat", AStat, 32'h06);

    // Framing error: nothing pushed, flag W1C.
    sendFrame(8'h55, 1'b0);
    readCheck("frameErrStat", AStat, 32'h26);
    busWrite(AStat, 32'h20);
    readCheck("frameErrClr", AStat, 32'h06);

    // Overrun: 9 frames into an 8-deep FIFO.
    for (int i = 0; i < 9; i++) sendFrame(8'h10 + 8'(i), 1'b1);
    readCheck("overrunStat", AStat, 32'h1A);
    for (int i = 0; i < 8; i++) readCheck($sformatf("rxOrder%0d", i), AData, 32'h10 + 32'(i));
    readCheck("overrunDrained", AStat, 32'h16);
    busWrite(AStat, 32'h10);
    readCheck("overrunClr", AStat, 32'h06);

    // Simultaneous read and write: write wins, read data is 0.
    @(negedge AClkH);
    AIoAddr = ABaud; AIoMosi = 32'h7; AIoWrSize = 3'b010; AIoRdSize = 3'b010;
    @(negedge AClkH);
    AIoWrSize = 3'b000; AIoRdSize = 3'b000;
    checkVal("rdWrMiso", AIoMiso, 32'h0);
    readCheck("rdWrBaud", ABaud, 32'h7);
    busWrite(ABaud, 32'h3);

    // Clock enable low: read data holds, strobes ignored.
    busRead(ABaud, d);
    checkVal("enPreRead", d, 32'h3);
    AClkHEn = 1'b0; AIoAddr = AStat; AIoRdSize = 3'b010;
    repeat (2) @(negedge AClkH);
    checkVal("enHoldMiso", AIoMiso, 32'h3);
    AIoRdSize = 3'b000; AIoAddr = ABaud; AIoMosi = 32'h9; AIoWrSize = 3'b010;
    @(negedge AClkH);
    AIoWrSize = 3'b000; AClkHEn = 1'b1;
    readCheck("enIgnoredWr", ABaud, 32'h3);

    // TX overflow with a stalled serialiser: first byte is in flight, 8 fill the FIFO.
    busWrite(ABaud, 32'hFFFF);
    for (int i = 0; i < 9; i++) busWrite(AData, 32'(i));
    readCheck("txFullStat", AStat, 32'h85);
    busWrite(AData, 32'h99);
    readCheck("txOverflowStat", AStat, 32'hC5);
    busWrite(AStat, 32'h40);
    readCheck("txOverflowClr", AStat, 32'h85);

    // Asynchronous reset mid-frame.
    checkVal("midFrameLow", {31'h0, ADataO}, 32'h0);
    #2 AResetH = 1'b1;
    #1 checkVal("rstAsyncDataO", {31'h0, ADataO}, 32'h1);
    @(negedge AClkH);
    AResetH = 1'b0;
    readCheck("postRstStat", AStat, 32'h06);
    readCheck("postRstBaud", ABaud, 32'd867);

`ifdef MI_UART_IRQ_EN
    busWrite(ABaud, 32'h3);
    busWrite(ARsv, 32'h1);
    repeat (2) @(negedge AClkH);
    checkVal("irqIdle", {31'h0, AIrq}, 32'h0);
    sendFrame(8'h5A, 1'b1);
    checkVal("irqRx", {31'h0, AIrq}, 32'h1);
    readCheck("irqData", AData, 32'h5A);
    repeat (2) @(negedge AClkH);
    checkVal("irqCleared", {31'h0, AIrq}, 32'h0);
`endif

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
